// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - shared state encoding and opcodes for the multi-cycle sequencer and decoder
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // Loads and stores are the only instructions that visit the data-memory handshake.
  function automatic logic is_mem_op(input logic [31:0] instr);
    return (instr[31:26] == OP_LW) || (instr[31:26] == OP_SW);
  endfunction

  function automatic logic is_store(input logic [31:0] instr);
    return instr[31:26] == OP_SW;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - memory handshakes and decode hand-off between sequencer and datapath
interface mc_ctrl_fsm_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        dec_valid;
  logic        dec_wreg;
  logic        dec_is_jmp;
  logic [31:0] dec_jmp_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_wr_en;
  logic [31:0] retired;
  logic        fault;

  // Sequencer side.
  modport master (
    output imem_req, imem_addr, ir, pc, dmem_req, dmem_we, rf_wr_en, retired, fault,
    input  imem_ack, imem_rdata, dec_valid, dec_wreg, dec_is_jmp, dec_jmp_addr, dmem_ack
  );

  // Memory / decode side.
  modport slave (
    input  imem_req, imem_addr, ir, pc, dmem_req, dmem_we, rf_wr_en, retired, fault,
    output imem_ack, imem_rdata, dec_valid, dec_wreg, dec_is_jmp, dec_jmp_addr, dmem_ack
  );

endinterface

// File: rtl/mc_ctrl_fsm_ack_timer.sv
// rtl/mc_ctrl_fsm_ack_timer.sv - wait-cycle counter shared by the fetch and data handshakes
module ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  logic [TW-1:0] cnt_q;

  // Count unacknowledged request cycles; stop at the limit so the value never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == TW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle fetch/decode/exec/mem/wb sequencer owning pc, ir and retire count
module mc_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] retired_q;
  logic        fault_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        rf_wr_en_q;

  logic [31:0] pc_d;
  logic        waiting;
  logic        ack_seen;
  logic        tmr_clear;
  logic        tmr_count;
  logic        tmr_expired;

  // Next PC for the WB cycle; the +4 simply wraps at 2^32.
  always_comb begin
    pc_d = bus.dec_is_jmp ? bus.dec_jmp_addr : pc_q + 32'd4;
  end

  // The timer runs only while a request is actually outstanding; any other cycle clears
  // it, so every state entry starts from zero.
  always_comb begin
    waiting   = ((state_q == ST_FETCH) && imem_req_q) || ((state_q == ST_MEM) && dmem_req_q);
    ack_seen  = (state_q == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
    tmr_count = waiting && !ack_seen;
    tmr_clear = !waiting;
  end

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .count_en_i(tmr_count),
    .expired_o (tmr_expired)
  );

  // Sequencer state, architectural registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Coming out of reset the request is still low: raise it first, and ignore any
          // ack that shows up before it is raised.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            ir_q       <= bus.imem_rdata;
            state_q    <= ST_DECODE;
          end else if (tmr_expired) begin
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end

        ST_DECODE: begin
          // Register-file read data settles for the new ir during this cycle.
          state_q <= ST_EXEC;
        end

        ST_EXEC: begin
          if (!bus.dec_valid) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else if (is_mem_op(ir_q)) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store(ir_q);
            state_q    <= ST_MEM;
          end else begin
            rf_wr_en_q <= bus.dec_wreg;
            state_q    <= ST_WB;
          end
        end

        ST_MEM: begin
          if (dmem_req_q && bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_wr_en_q <= bus.dec_wreg && !is_store(ir_q);
            state_q    <= ST_WB;
          end else if (tmr_expired) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end

        ST_WB: begin
          // Retire and launch the next fetch from the updated pc in the same edge.
          rf_wr_en_q <= 1'b0;
          pc_q       <= pc_d;
          retired_q  <= retired_q + 32'd1;
          imem_req_q <= 1'b1;
          state_q    <= ST_FETCH;
        end

        ST_FAULT: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          rf_wr_en_q <= 1'b0;
          fault_q    <= 1'b1;
        end

        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          rf_wr_en_q <= 1'b0;
          fault_q    <= 1'b1;
          state_q    <= ST_FAULT;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.pc        = pc_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.rf_wr_en  = rf_wr_en_q;
  assign bus.retired   = retired_q;
  assign bus.fault     = fault_q;

endmodule
